// File: rtl/mxu_host_pkg.sv
// Shared types and sizing helpers for the MXU host controller.
// Sizing is expressed as functions of DIM so any instance can derive its own counts.
package mxu_host_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int unsigned load_words(input int unsigned dim);
    return 2 + 3 * dim * dim;
  endfunction

  function automatic int unsigned res_words(input int unsigned dim);
    return dim * dim;
  endfunction

  localparam int unsigned DEF_DIM    = 2;
  localparam int unsigned LOAD_WORDS = load_words(DEF_DIM);
  localparam int unsigned RES_WORDS  = res_words(DEF_DIM);

endpackage

// File: rtl/mxu_result_serializer.sv
// Buffers one captured result matrix and streams it out row-major
// over a valid/ready handshake; o_done pulses on the final handshake.
module mxu_result_serializer #(
  parameter int unsigned EW = 8,
  parameter int unsigned N  = 4
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_capture,
  input  logic [N*EW-1:0] i_data,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [EW-1:0]   o_data,
  output logic            o_last,
  output logic            o_done
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N*EW-1:0] r_buf;
  logic [IW-1:0]   r_idx;
  logic            r_valid;
  logic            w_last;
  logic            w_fire;

  assign w_last = r_valid && (r_idx == IW'(N - 1));
  assign w_fire = r_valid && i_ready;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_buf   <= i_data;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) o_data = r_buf[i*EW +: EW];
    end
  end

  assign o_valid = r_valid;
  assign o_last  = w_last;
  assign o_done  = w_fire && w_last;

endmodule

// File: rtl/mxu_host_ctrl.sv
// Host-side controller for temporal_mxu: loads operands, kicks a job, waits, drains result.
// Optional MXU_HOST_TIMEOUT_EN adds a bounded result wait with a sticky timeout_err flag.
module mxu_host_ctrl
  import mxu_host_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = 4,
  parameter int unsigned DIM            = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BIT_WIDTH-1:0]             in_data,
  output logic                             mxu_start,
  output logic [DIM*DIM*BIT_WIDTH-1:0]     mxu_A,
  output logic [DIM*DIM*BIT_WIDTH-1:0]     mxu_B,
  output logic [DIM*DIM*BIT_WIDTH-1:0]     mxu_C,
  output logic [BIT_WIDTH-1:0]             mxu_alpha,
  output logic [BIT_WIDTH-1:0]             mxu_beta,
  input  logic                             mxu_out_valid,
  input  logic [DIM*DIM*2*BIT_WIDTH-1:0]   mxu_out,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [2*BIT_WIDTH-1:0]           res_data,
  output logic                             res_last,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int unsigned NW = load_words(DIM);
  localparam int unsigned NE = res_words(DIM);
  localparam int unsigned CW = $clog2(NW);

  state_t                       r_state;
  logic [CW-1:0]                r_cnt;
  logic [BIT_WIDTH-1:0]         r_alpha;
  logic [BIT_WIDTH-1:0]         r_beta;
  logic [DIM*DIM*BIT_WIDTH-1:0] r_A;
  logic [DIM*DIM*BIT_WIDTH-1:0] r_B;
  logic [DIM*DIM*BIT_WIDTH-1:0] r_C;

  logic w_load_fire;
  logic w_load_last;
  logic w_capture;
  logic w_timeout;
  logic w_drain_done;

  assign w_load_fire = (r_state == LOAD) && in_valid;
  assign w_load_last = w_load_fire && (r_cnt == CW'(NW - 1));
  // mxu_out_valid is only meaningful in WAIT; a stale high elsewhere is ignored.
  assign w_capture   = (r_state == WAIT) && mxu_out_valid;

`ifdef MXU_HOST_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout;

  assign w_timeout = (r_state == WAIT) && !mxu_out_valid &&
                     (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == KICK) r_wait_cnt <= '0;
      else if (r_state == WAIT && !mxu_out_valid) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout) r_timeout <= 1'b1;
      else if (w_load_fire) r_timeout <= 1'b0;
    end
  end

  assign timeout_err = r_timeout;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= LOAD;
      r_cnt   <= '0;
    end else begin
      if (w_load_fire) r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
      case (r_state)
        LOAD:    if (w_load_last) r_state <= KICK;
        KICK:    r_state <= WAIT;
        WAIT:    if (w_capture) r_state <= DRAIN;
                 else if (w_timeout) r_state <= LOAD;
        DRAIN:   if (w_drain_done) r_state <= LOAD;
        default: r_state <= LOAD;
      endcase
    end
  end

  // Word order: alpha, beta, A, B, C (each row-major, element 0 at the LSBs).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alpha <= '0;
      r_beta  <= '0;
      r_A     <= '0;
      r_B     <= '0;
      r_C     <= '0;
    end else if (w_load_fire) begin
      if (r_cnt == CW'(0)) r_alpha <= in_data;
      if (r_cnt == CW'(1)) r_beta  <= in_data;
      for (int unsigned i = 0; i < NE; i++) begin
        if (r_cnt == CW'(2 + i))          r_A[i*BIT_WIDTH +: BIT_WIDTH] <= in_data;
        if (r_cnt == CW'(2 + NE + i))     r_B[i*BIT_WIDTH +: BIT_WIDTH] <= in_data;
        if (r_cnt == CW'(2 + 2 * NE + i)) r_C[i*BIT_WIDTH +: BIT_WIDTH] <= in_data;
      end
    end
  end

  mxu_result_serializer #(
    .EW (2 * BIT_WIDTH),
    .N  (NE)
  ) u_ser (
    .clk       (clk),
    .i_rst_n   (reset_n),
    .i_capture (w_capture),
    .i_data    (mxu_out),
    .i_ready   (res_ready),
    .o_valid   (res_valid),
    .o_data    (res_data),
    .o_last    (res_last),
    .o_done    (w_drain_done)
  );

  assign in_ready  = (r_state == LOAD);
  assign mxu_start = (r_state == KICK);
  assign busy      = (r_state != LOAD);
  assign mxu_alpha = r_alpha;
  assign mxu_beta  = r_beta;
  assign mxu_A     = r_A;
  assign mxu_B     = r_B;
  assign mxu_C     = r_C;

endmodule

// File: tb/tb_mxu_host_ctrl.sv
// Directed scoreboard bench for mxu_host_ctrl; result elements are checked by a monitor.
// Build with MXU_HOST_TIMEOUT_EN defined to exercise the wait-timeout path.
module tb_mxu_host_ctrl;
  import mxu_host_pkg::*;

  localparam int unsigned BW = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned NW = LOAD_WORDS;
  localparam int unsigned NE = RES_WORDS;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_data;
  logic          mxu_start;
  logic [15:0]   mxu_A, mxu_B, mxu_C;
  logic [3:0]    mxu_alpha, mxu_beta;
  logic          mxu_out_valid;
  logic [31:0]   mxu_out;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic          res_last;
  logic          busy;
  logic          timeout_err;

  mxu_host_ctrl #(
    .BIT_WIDTH      (BW),
    .DIM            (D),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .mxu_start     (mxu_start),
    .mxu_A         (mxu_A),
    .mxu_B         (mxu_B),
    .mxu_C         (mxu_C),
    .mxu_alpha     (mxu_alpha),
    .mxu_beta      (mxu_beta),
    .mxu_out_valid (mxu_out_valid),
    .mxu_out       (mxu_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_last      (res_last),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned start_cnt = 0;
  int unsigned n_jobs  = 0;
  logic [8:0]  exp_q[$];
  logic [3:0]  ldw [0:NW-1];
  logic [3:0]  pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops one expected element per handshake, checks stall stability.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid", res_valid, 1);
        check("stall_data", res_data, prev_data);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_res: got data 0x%0h, want no element", res_data);
        end else begin
          check("res_data", res_data, exp_q[0][7:0]);
          check("res_last", res_last, exp_q[0][8]);
          void'(exp_q.pop_front());
        end
      end
      prev_valid <= res_valid;
      prev_ready <= res_ready;
      prev_data  <= res_data;
    end
  end

  always @(negedge clk) begin
    if (reset_n && mxu_start) start_cnt <= start_cnt + 1;
  end

  task automatic load_job(input int unsigned first);
    for (int unsigned i = first; i < NW; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = ldw[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_jobs++;
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mxu_start) seen = 1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL start_wait: got no mxu_start in 50 cycles, want one");
    end
  endtask

  task automatic respond(input logic [31:0] o, input bit hold);
    bit seen = 0;
    for (int unsigned e = 0; e < NE; e++)
      exp_q.push_back({(e == NE - 1), o[e*8 +: 8]});
    mxu_out       = o;
    mxu_out_valid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    check("capture_seen", seen, 1);
    if (!hold) mxu_out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    check(name, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; in_data = '0;
    mxu_out_valid = 1'b0; mxu_out = '0; res_ready = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", mxu_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_last", res_last, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_A", mxu_A, 0);
    check("rst_alpha", mxu_alpha, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Job 1: basic load, kick, 5-cycle response, full drain.
    ldw = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd4, 4'd15};
    load_job(0);
    wait_start();
    check("j1_alpha", mxu_alpha, 4'd2);
    check("j1_beta", mxu_beta, 4'd1);
    check("j1_C11", mxu_C[15:12], 4'd15);
    check("j1_A", mxu_A, 16'h1111);
    check("j1_B", mxu_B, 16'h1111);
    check("j1_C", mxu_C, 16'hF421);
    repeat (5) @(posedge clk);
    #1;
    respond(32'h13080605, 0);
    wait_idle("j1_idle");
    check("j1_busy", busy, 0);
    check("j1_starts", start_cnt, n_jobs);
    check("j1_q_empty", exp_q.size(), 0);

    // Job 2: in_valid during WAIT is refused; res_ready toggles 1,0,0,1 in DRAIN.
    ldw = '{4'd3, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    load_job(0);
    wait_start();
    in_valid = 1'b1;
    in_data  = 4'h7;
    repeat (3) begin
      @(negedge clk);
      check("wait_in_ready", in_ready, 0);
    end
    check("wait_alpha", mxu_alpha, 4'd3);
    check("wait_beta", mxu_beta, 4'd2);
    check("wait_A", mxu_A, 16'h4321);
    check("wait_B", mxu_B, 16'h8765);
    check("wait_C", mxu_C, 16'hCBA9);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    respond(32'hFF563412, 0);
    begin
      bit done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
        @(posedge clk); #1;
        res_ready = pat[k % 4];
        done = !busy;
      end
    end
    res_ready = 1'b1;
    wait_idle("j2_idle");
    check("j2_q_empty", exp_q.size(), 0);
    check("j2_starts", start_cnt, n_jobs);

    // Job 3 leaves mxu_out_valid high; job 4 must capture only its own WAIT-time result.
    ldw = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    load_job(0);
    wait_start();
    repeat (2) @(posedge clk);
    #1;
    respond(32'hA4A3A2A1, 1);
    wait_idle("j3_idle");
    @(negedge clk);
    check("stale_no_res", res_valid, 0);
    check("stale_in_ready", in_ready, 1);
    ldw = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd1, 4'd2, 4'd2};
    load_job(0);
    wait_start();
    respond(32'hB4B3B2B1, 0);
    wait_idle("j4_idle");
    check("j4_q_empty", exp_q.size(), 0);
    check("j4_starts", start_cnt, n_jobs);

    // Job 5: no response from the model.
    ldw = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    load_job(0);
    wait_start();
`ifdef MXU_HOST_TIMEOUT_EN
    begin
      int unsigned wc = 0;
      bit ended = 0;
      for (int i = 0; i < 20 && !ended; i++) begin
        @(negedge clk);
        if (busy) wc++;
        else ended = 1;
      end
      check("to_wait_cycles", wc, 8);
    end
    check("to_err_set", timeout_err, 1);
    check("to_busy", busy, 0);
    check("to_in_ready", in_ready, 1);
    check("to_no_res", res_valid, 0);
    check("to_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = ldw[0];
    check("to_err_held", timeout_err, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("to_err_clear", timeout_err, 0);
    load_job(1);
    wait_start();
    respond(32'hC4C3C2C1, 0);
    wait_idle("to_next_idle");
`else
    repeat (40) @(negedge clk);
    check("nto_busy", busy, 1);
    check("nto_err", timeout_err, 0);
    check("nto_no_res", res_valid, 0);
    respond(32'hC4C3C2C1, 0);
    wait_idle("nto_idle");
`endif
    check("j5_q_empty", exp_q.size(), 0);
    check("j5_starts", start_cnt, n_jobs);

    // Reset asserted mid-DRAIN after two elements.
    ldw = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13, 4'd12};
    load_job(0);
    wait_start();
    res_ready = 1'b0;
    respond(32'hD4D3D2D1, 0);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 res_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_last", res_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", mxu_start, 0);
    check("mid_rst_remaining", exp_q.size(), 2);
    exp_q.delete();
    res_ready = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_A", mxu_A, 0);
    check("post_rst_alpha", mxu_alpha, 0);
    repeat (5) @(negedge clk);
    check("post_rst_no_res", res_valid, 0);
    check("post_rst_starts", start_cnt, n_jobs);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mxu_host_ctrl.md
MXU_HOST_CTRL -- requirements
Module: mxu_host_ctrl

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH, default 4, operand element width; DIM, default 2, square matrix dimension; TIMEOUT_CYCLES, default 256, result-wait limit.
REQ-002 Ports SHALL be, in order:
- clk, in, 1, single clock, all logic rising-edge.
- reset_n, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, load word valid.
- in_ready, out, 1, load word accepted when in_valid && in_ready.
- in_data, in, BIT_WIDTH, load word.
- mxu_start, out, 1, one-cycle job start to temporal_mxu.
- mxu_A, mxu_B, mxu_C, out, DIM*DIM*BIT_WIDTH each, packed [row][col] operands.
- mxu_alpha, mxu_beta, out, BIT_WIDTH each, scale factors.
- mxu_out_valid, in, 1, result-ready from temporal_mxu.
- mxu_out, in, DIM*DIM*2*BIT_WIDTH, packed [row][col] result.
- res_valid, out, 1, result stream valid.
- res_ready, in, 1, result stream ready.
- res_data, out, 2*BIT_WIDTH, result element.
- res_last, out, 1, final element of a job.
- busy, out, 1, high in any state except LOAD.
- timeout_err, out, 1, sticky wait-timeout flag.

Function
REQ-003 The FSM SHALL have four states: LOAD, KICK, WAIT and DRAIN.
REQ-004 In LOAD, in_ready SHALL be 1; in every other state in_ready SHALL be 0.
REQ-005 Accepted load words SHALL fill registers in this fixed order: alpha, beta, A row-major, B row-major, C row-major. This is 2+3*DIM*DIM words (14 at default).
REQ-006 When the last load word is accepted, the FSM SHALL go LOAD->KICK on the next edge. The word counter SHALL then reset to 0.
REQ-007 In KICK, mxu_start SHALL be 1 for exactly one cycle, then KICK->WAIT. mxu_start SHALL be 0 in every other state.
REQ-008 mxu_A, mxu_B, mxu_C, mxu_alpha and mxu_beta SHALL be driven from registers and held stable from KICK until the next LOAD write.
REQ-009 mxu_out_valid SHALL be sampled only in WAIT. Its value during LOAD, KICK and DRAIN SHALL be ignored, so stale high from a prior job is harmless.
REQ-010 On the first WAIT cycle with mxu_out_valid=1, mxu_out SHALL be captured into a result buffer and the FSM SHALL go WAIT->DRAIN.
REQ-011 In DRAIN, res_valid SHALL be 1 and res_data SHALL present buffered elements row-major, one per res_valid && res_ready handshake.
REQ-012 res_data and res_valid SHALL hold stable while res_ready=0.
REQ-013 res_last SHALL be 1 with element index DIM*DIM-1. That handshake SHALL move DRAIN->LOAD.
REQ-014 Result elements SHALL be passed through bit-exact at width 2*BIT_WIDTH, with no arithmetic in this block.
REQ-015 A new load SHALL begin only after a job fully drains; there is no overlap of load and drain.

Reset
REQ-016 While reset_n=0, all of the following SHALL hold asynchronously: state=LOAD, counters=0, mxu_start=0, res_valid=0, res_last=0, busy=0, timeout_err=0, and all operand/result registers=0.
REQ-017 Reset asserted in any state, including mid-WAIT or mid-DRAIN, SHALL abort the job with no further mxu_start or res_valid.

Configuration
REQ-018 With macro MXU_HOST_TIMEOUT_EN defined, a wait counter SHALL run as follows:
- It starts at 0 on entry to WAIT.
- It increments each WAIT cycle.
- On reaching TIMEOUT_CYCLES without mxu_out_valid, it sets timeout_err=1 and moves WAIT->LOAD with no drain.
REQ-019 timeout_err SHALL clear on the first accepted load word of the next job.
REQ-020 Without MXU_HOST_TIMEOUT_EN, WAIT SHALL persist indefinitely, timeout_err SHALL be tied 0, and no wait counter SHALL be synthesized.

Structure
REQ-021 Shared package mxu_host_pkg SHALL hold:
- the state enum typedef (LOAD, KICK, WAIT, DRAIN);
- localparams LOAD_WORDS = 2+3*DIM*DIM and RES_WORDS = DIM*DIM, as functions of DIM.
REQ-022 Sub-module mxu_result_serializer SHALL own the result buffer, element index, res_valid/res_data/res_last and the handshake. The top FSM SHALL instantiate it.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load 2,1, A=1,1,1,1, B=1,1,1,1, C=1,2,4,15. Expect mxu_alpha=2, mxu_beta=1, mxu_C[1][1]=15 and a one-cycle mxu_start. Model asserts mxu_out_valid 5 cycles later with out={5,6,8,19}. Expect res_data 5,6,8,19 in order, res_last on 19, and busy=0 afterward.
- res_ready toggling 1,0,0,1 in DRAIN: each element is held while stalled, and no element is duplicated or skipped.
- in_valid=1 during WAIT: in_ready=0 and operand registers are unchanged.
- mxu_out_valid held high from the previous job through the next LOAD/KICK: capture occurs only in WAIT, and the first captured result belongs to the new job.
- With MXU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=8, model never responds: timeout_err=1 after 8 WAIT cycles, state returns to LOAD, no res_valid, and timeout_err clears on the next load word.
- reset_n=0 asserted mid-DRAIN after 2 elements: res_valid=0 immediately, and after release busy=0 and in_ready=1.
